// File: rtl/eth_sched_pkg.sv
// Shared types and helpers for the Ethernet line TX scheduler.
// State encodings are visible on state_o, so they are fixed here.
package eth_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FILL = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_SENDING   = 3'd4,
    ST_GAP       = 3'd5
  } sched_state_t;

  localparam logic TX_SEL_VIDEO = 1'b0;
  localparam logic TX_SEL_CTRL  = 1'b1;

  localparam int TMR_W = 16;

  // Fill level required before launch: the prefill threshold, clipped to the line length.
  function automatic logic [15:0] min_fill(input logic [15:0] prefill, input logic [15:0] pixels);
    return (pixels < prefill) ? pixels : prefill;
  endfunction

endpackage

// File: rtl/eth_sched_timer.sv
// Loadable down-counter with a zero flag; one instance serves the fill,
// busy and inter-packet-gap waits since only one of them is active at a time.
module eth_sched_timer
  import eth_sched_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/eth_line_tx_scheduler.sv
// Shares the UDP transmitter between video-line packets and control replies.
// Define TX_STATS_EN to add saturating video_pkt_cnt / drop_cnt outputs.
module eth_line_tx_scheduler
  import eth_sched_pkg::*;
#(
  parameter int FIFO_AW         = 9,
  parameter int PREFILL         = 256,
  parameter int IPG_CYCLES      = 12,
  parameter int FILL_TIMEOUT    = 4096,
  parameter int BUSY_TIMEOUT    = 16,
  parameter int MAX_VIDEO_BURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic [15:0]        line_number,
  input  logic [15:0]        pixels_per_line,
  input  logic [FIFO_AW:0]   fifo_rdusedw,
  input  logic               ctrl_req,
  input  logic [15:0]        ctrl_len,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic               tx_sel,
  output logic [15:0]        tx_data_length,
  output logic [15:0]        tx_line_number,
  output logic [15:0]        frame_id,
  output logic               ctrl_ack,
  output logic               err_busy_timeout,
  output logic [2:0]         state_o
`ifdef TX_STATS_EN
  ,
  output logic [31:0]        video_pkt_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  // state     | meaning
  // IDLE      | arbitrate: ctrl reply vs pending video line
  // WAIT_FILL | wait for prefill; discard empty line or drop on timeout
  // ISSUE     | one-cycle tx_start, packet descriptor latched
  // WAIT_BUSY | wait for transmitter to pick up the packet
  // SENDING   | transmitter busy; packet ends when tx_busy falls
  // GAP       | inter-packet gap

  localparam logic [TMR_W-1:0] FILL_LD   = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BUSY_LD   = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] IPG_LD    = TMR_W'(IPG_CYCLES - 1);
  localparam logic [15:0]      PREFILL_W = 16'(PREFILL);
  localparam logic [7:0]       BURST_MAX = 8'(MAX_VIDEO_BURST);

  sched_state_t     state, state_next;
  logic             pending, launched;
  logic [15:0]      pend_line, pend_pixels;
  logic [7:0]       burst_cnt;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             fill_ok, discard, fill_to, busy_to, pkt_done;
  logic             sel_next, video_launch, ctrl_launch, clear_pend;

  eth_sched_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign fill_ok = 16'(fifo_rdusedw) >= min_fill(PREFILL_W, pend_pixels);

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    sel_next   = TX_SEL_VIDEO;
    discard    = 1'b0;
    fill_to    = 1'b0;
    busy_to    = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_req && (!pending || burst_cnt >= BURST_MAX)) begin
          state_next = ST_ISSUE;
          sel_next   = TX_SEL_CTRL;
          tmr_load   = 1'b1;
          tmr_val    = BUSY_LD;
        end else if (pending) begin
          state_next = ST_WAIT_FILL;
          tmr_load   = 1'b1;
          tmr_val    = FILL_LD;
        end
      end
      ST_WAIT_FILL: begin
        if (pend_pixels == '0) begin
          discard    = 1'b1;
          state_next = ST_IDLE;
        end else if (fill_ok) begin
          state_next = ST_ISSUE;
          tmr_load   = 1'b1;
          tmr_val    = BUSY_LD;
        end else if (tmr_zero) begin
          fill_to    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = ST_SENDING;
        end else if (tmr_zero) begin
          busy_to    = 1'b1;
          state_next = ST_GAP;
          tmr_load   = 1'b1;
          tmr_val    = IPG_LD;
        end
      end
      ST_SENDING: begin
        if (!tx_busy) begin
          pkt_done   = 1'b1;
          state_next = ST_GAP;
          tmr_load   = 1'b1;
          tmr_val    = IPG_LD;
        end
      end
      ST_GAP: if (tmr_zero) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign video_launch = (state == ST_WAIT_FILL) && (state_next == ST_ISSUE);
  assign ctrl_launch  = (state == ST_IDLE) && (state_next == ST_ISSUE);
  // An abandoned video packet also retires its line so it is not relaunched forever.
  assign clear_pend   = discard || fill_to ||
                        ((pkt_done || busy_to) && (tx_sel == TX_SEL_VIDEO));

  assign tx_start = (state == ST_ISSUE);
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      pending          <= 1'b0;
      launched         <= 1'b0;
      pend_line        <= '0;
      pend_pixels      <= '0;
      burst_cnt        <= '0;
      frame_id         <= '0;
      tx_sel           <= TX_SEL_VIDEO;
      tx_data_length   <= '0;
      tx_line_number   <= '0;
      ctrl_ack         <= 1'b0;
      err_busy_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (frame_start) frame_id <= frame_id + 16'd1;
      if (video_launch || ctrl_launch) begin
        tx_sel         <= sel_next;
        tx_data_length <= (sel_next == TX_SEL_CTRL) ? ctrl_len : pend_pixels;
        if (video_launch) tx_line_number <= pend_line;
      end
      ctrl_ack <= pkt_done && (tx_sel == TX_SEL_CTRL);
      if (busy_to) err_busy_timeout <= 1'b1;
      // A line arriving once the pending one is committed to the wire is dropped.
      if (line_start && !launched && !video_launch) begin
        pending     <= 1'b1;
        pend_line   <= line_number;
        pend_pixels <= pixels_per_line;
      end else if (clear_pend) begin
        pending  <= 1'b0;
        launched <= 1'b0;
      end
      if (video_launch) launched <= 1'b1;
      if (!ctrl_req || ctrl_launch) begin
        burst_cnt <= '0;
      end else if (video_launch && burst_cnt < BURST_MAX) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

`ifdef TX_STATS_EN
  logic [1:0] drop_inc;
  assign drop_inc = {1'b0, fill_to} + {1'b0, line_start && (pending || launched)};

  always_ff @(posedge clk) begin
    if (reset) begin
      video_pkt_cnt <= '0;
      drop_cnt      <= '0;
    end else begin
      if (video_launch && video_pkt_cnt != '1) video_pkt_cnt <= video_pkt_cnt + 32'd1;
      if ({1'b0, drop_cnt} + 17'(drop_inc) > 17'h0FFFF) drop_cnt <= '1;
      else                                               drop_cnt <= drop_cnt + 16'(drop_inc);
    end
  end
`endif

endmodule

// File: tb/tb_eth_line_tx_scheduler.sv
// Directed bench for eth_line_tx_scheduler: vector table plus hand-built sequences
// for fill timeout, prefill ramp, ctrl arbitration, busy timeout and mid-packet reset.
module tb_eth_line_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset, frame_start, line_start, ctrl_req, tx_busy;
  logic [15:0] line_number, pixels_per_line, ctrl_len;
  logic [9:0]  fifo_rdusedw;
  logic        tx_start, tx_sel, ctrl_ack, err_busy_timeout;
  logic [15:0] tx_data_length, tx_line_number, frame_id;
  logic [2:0]  state_o;
`ifdef TX_STATS_EN
  logic [31:0] video_pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  eth_line_tx_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .line_start       (line_start),
    .line_number      (line_number),
    .pixels_per_line  (pixels_per_line),
    .fifo_rdusedw     (fifo_rdusedw),
    .ctrl_req         (ctrl_req),
    .ctrl_len         (ctrl_len),
    .tx_busy          (tx_busy),
    .tx_start         (tx_start),
    .tx_sel           (tx_sel),
    .tx_data_length   (tx_data_length),
    .tx_line_number   (tx_line_number),
    .frame_id         (frame_id),
    .ctrl_ack         (ctrl_ack),
    .err_busy_timeout (err_busy_timeout),
    .state_o          (state_o)
`ifdef TX_STATS_EN
    ,
    .video_pkt_cnt    (video_pkt_cnt),
    .drop_cnt         (drop_cnt)
`endif
  );

  typedef struct {
    logic [15:0] line_no;
    logic [15:0] pixels;
    logic [9:0]  fill;
    logic        fs;
    logic        exp_launch;
    logic [15:0] exp_len;
    int          busy_len;
  } vec_t;

  int cyc = 0;
  int n_err = 0, n_checks = 0;
  int start_cnt = 0, ack_cnt = 0, bad_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) start_cnt++;
    if (ctrl_ack) ack_cnt++;
    if (tx_start && tx_busy) bad_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_sel"},   32'(tx_sel), 0);
    check({tag, "_len"},      32'(tx_data_length), 0);
    check({tag, "_line"},     32'(tx_line_number), 0);
    check({tag, "_frame_id"}, 32'(frame_id), 0);
    check({tag, "_ctrl_ack"}, 32'(ctrl_ack), 0);
    check({tag, "_err"},      32'(err_busy_timeout), 0);
    check({tag, "_state"},    32'(state_o), 0);
  endtask

  task automatic wait_start(input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (tx_start) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no tx_start within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input logic eq, input int budget,
                            input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if ((state_o == s) == eq) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: state condition not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_line(input logic [15:0] ln, input logic [15:0] px, input logic fs);
    line_start      = 1'b1;
    line_number     = ln;
    pixels_per_line = px;
    frame_start     = fs;
    tick();
    line_start  = 1'b0;
    frame_start = 1'b0;
  endtask

  // Called in the tx_start cycle: busy rises two cycles later for len cycles.
  task automatic run_busy(input int len, output int fall);
    tick();
    tick();
    tx_busy = 1'b1;
    repeat (len) tick();
    tx_busy = 1'b0;
    fall = cyc;
  endtask

  initial begin : main
    vec_t vecs[5];
    int   t, c, f, w, e, s0, hit, f100, fv, prev_fall;
    int   exp_frame, exp_video;

    vecs[0] = '{16'd5, 16'd1920, 10'd300, 1'b0, 1'b1, 16'd1920, 100};
    vecs[1] = '{16'd6, 16'd1000, 10'd256, 1'b1, 1'b1, 16'd1000, 20};
    vecs[2] = '{16'd7, 16'd200,  10'd200, 1'b1, 1'b1, 16'd200,  20};
    vecs[3] = '{16'd8, 16'd0,    10'd500, 1'b0, 1'b0, 16'd0,    0};
    vecs[4] = '{16'd9, 16'd1,    10'd1,   1'b1, 1'b1, 16'd1,    5};
    exp_frame = 0;
    exp_video = 0;

    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0; ctrl_req = 1'b0; tx_busy = 1'b0;
    line_number = '0; pixels_per_line = '0; ctrl_len = '0; fifo_rdusedw = '0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Fill timeout: fill stuck at 10, line dropped after FILL_TIMEOUT cycles in WAIT_FILL.
    fifo_rdusedw = 10'd10;
    pulse_line(16'd20, 16'd300, 1'b0);
    wait_state(3'd1, 1'b1, 5, "fto_enter", w);
    wait_state(3'd1, 1'b0, 5000, "fto_leave", e);
    check("fto_duration", 32'(e - w), 4096);
    check("fto_state_idle", 32'(state_o), 0);
    check("fto_no_start", 32'(start_cnt), 0);
    fifo_rdusedw = 10'd500;
    repeat (10) tick();
    check("fto_line_dropped", 32'(start_cnt), 0);
`ifdef TX_STATS_EN
    check("fto_drop_cnt", 32'(drop_cnt), 1);
`endif

    for (int i = 0; i < 5; i++) begin
      s0 = start_cnt;
      fifo_rdusedw = vecs[i].fill;
      c = cyc;
      pulse_line(vecs[i].line_no, vecs[i].pixels, vecs[i].fs);
      if (vecs[i].fs) exp_frame++;
      check($sformatf("v%0d_frame_id", i), 32'(frame_id), 32'(exp_frame));
      if (vecs[i].exp_launch) begin
        exp_video++;
        wait_start(10, $sformatf("v%0d_start", i), t);
        check($sformatf("v%0d_latency", i), 32'(t - c), 3);
        check($sformatf("v%0d_sel", i), 32'(tx_sel), 0);
        check($sformatf("v%0d_len", i), 32'(tx_data_length), 32'(vecs[i].exp_len));
        check($sformatf("v%0d_line", i), 32'(tx_line_number), 32'(vecs[i].line_no));
        run_busy(vecs[i].busy_len, f);
        tick();
        check($sformatf("v%0d_gap_state", i), 32'(state_o), 5);
        wait_state(3'd0, 1'b1, 40, $sformatf("v%0d_idle", i), w);
        check($sformatf("v%0d_start_once", i), 32'(start_cnt - s0), 1);
      end else begin
        repeat (8) tick();
        check($sformatf("v%0d_no_start", i), 32'(start_cnt - s0), 0);
        check($sformatf("v%0d_idle", i), 32'(state_o), 0);
      end
    end

    // Short line: fill ramps 50,60,...,100; launch the cycle after it reaches 100.
    fifo_rdusedw = 10'd50;
    pulse_line(16'd40, 16'd100, 1'b0);
    hit = -1;
    f100 = -1;
    for (int k = 1; k < 20; k++) begin
      if (tx_start) begin
        hit = cyc;
        break;
      end
      fv = (50 + 10 * k > 100) ? 100 : 50 + 10 * k;
      fifo_rdusedw = 10'(fv);
      if (fv == 100 && f100 < 0) f100 = cyc;
      tick();
    end
    exp_video++;
    check("short_launch_cycle", 32'(hit - f100), 1);
    check("short_len", 32'(tx_data_length), 100);
    check("short_line", 32'(tx_line_number), 40);
    run_busy(20, f);
    wait_state(3'd0, 1'b1, 40, "short_idle", w);

    // Arbitration: ctrl held while lines keep coming; ctrl goes after 8 videos.
    fifo_rdusedw = 10'd500;
    pulse_line(16'd100, 16'd500, 1'b0);
    ctrl_req = 1'b1;
    ctrl_len = 16'd64;
    prev_fall = 0;
    for (int i = 0; i < 9; i++) begin
      wait_start(40, $sformatf("arb%0d_start", i), t);
      if (i > 0) check($sformatf("arb%0d_gap_ok", i), 32'(t - prev_fall >= 12), 1);
      if (i < 8) begin
        exp_video++;
        check($sformatf("arb%0d_sel", i), 32'(tx_sel), 0);
        check($sformatf("arb%0d_line", i), 32'(tx_line_number), 32'(100 + i));
      end else begin
        check("arb_ctrl_sel", 32'(tx_sel), 1);
        check("arb_ctrl_len", 32'(tx_data_length), 64);
        check("arb_ack_before_end", 32'(ack_cnt), 0);
      end
      run_busy(10, f);
      prev_fall = f;
      tick();
      if (i < 8) pulse_line(16'(101 + i), 16'd500, 1'b0);
    end
    tick();
    tick();
    check("arb_ack_once", 32'(ack_cnt), 1);
    ctrl_req = 1'b0;
    wait_start(40, "arb_after_ctrl", t);
    exp_video++;
    check("arb_after_sel", 32'(tx_sel), 0);
    check("arb_after_line", 32'(tx_line_number), 108);
    check("arb_after_gap_ok", 32'(t - prev_fall >= 12), 1);
    run_busy(10, f);
    wait_state(3'd0, 1'b1, 40, "arb_idle", w);

    // Busy timeout: tx_busy never rises.
    s0 = start_cnt;
    pulse_line(16'd30, 16'd500, 1'b0);
    wait_start(10, "bto_start", t);
    exp_video++;
    repeat (15) tick();
    check("bto_not_yet", 32'(err_busy_timeout), 0);
    tick();
    check("bto_set", 32'(err_busy_timeout), 1);
    wait_state(3'd0, 1'b1, 40, "bto_idle", w);
    repeat (20) tick();
    check("bto_sticky", 32'(err_busy_timeout), 1);
    check("bto_no_relaunch", 32'(start_cnt - s0), 1);

    // Reset during a ctrl packet in SENDING.
    ctrl_req = 1'b1;
    ctrl_len = 16'd77;
    wait_start(10, "rst_ctrl_start", t);
    check("rst_ctrl_sel", 32'(tx_sel), 1);
    check("rst_ctrl_len", 32'(tx_data_length), 77);
    tick();
    tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    check("rst_sending", 32'(state_o), 4);
    check("rst_err_still_set", 32'(err_busy_timeout), 1);
    check("rst_frame_before", 32'(frame_id), 32'(exp_frame));
`ifdef TX_STATS_EN
    check("stats_video", video_pkt_cnt, 32'(exp_video));
    check("stats_drop", 32'(drop_cnt), 1);
`endif
    reset = 1'b1;
    tick();
    check_zero("midrst");
`ifdef TX_STATS_EN
    check("midrst_video", video_pkt_cnt, 0);
    check("midrst_drop", 32'(drop_cnt), 0);
`endif
    tx_busy  = 1'b0;
    ctrl_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_state", 32'(state_o), 0);
    check("post_rst_no_start", 32'(tx_start), 0);
    check("ack_total", 32'(ack_cnt), 1);
    check("start_while_busy", 32'(bad_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
